// File: rtl/ball_pkg.sv
// Shared defaults and FSM encoding for the bouncing-ball motion block.
package ball_pkg;

  localparam int unsigned H_ACTIVE_DEF  = 640;
  localparam int unsigned V_ACTIVE_DEF  = 480;
  localparam int unsigned BALL_SIZE_DEF = 20;
  localparam int unsigned INIT_X_DEF    = 320;
  localparam int unsigned INIT_Y_DEF    = 240;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    COMMIT = 2'd2
  } ball_state_e;

endpackage

// File: rtl/ball_axis.sv
// One-axis step, clamp and bounce. Arithmetic is 11 bits wide so pos+step
// and MIN+step never wrap.
module ball_axis #(
  parameter int unsigned MIN_POS = 20,
  parameter int unsigned MAX_POS = 619
) (
  input  logic [9:0] pos_i,
  input  logic       dir_i,
  input  logic [2:0] step_i,
  output logic [9:0] pos_o,
  output logic       dir_o,
  output logic       bounce_o
);

  logic [10:0] pos_w;
  logic [10:0] step_w;
  logic [10:0] sum_w;
  logic [10:0] lim_lo_w;

  always_comb begin
    pos_w    = {1'b0, pos_i};
    step_w   = {8'b0, step_i};
    sum_w    = pos_w + step_w;
    lim_lo_w = 11'(MIN_POS) + step_w;
    pos_o    = pos_i;
    dir_o    = dir_i;
    bounce_o = 1'b0;
    if (dir_i) begin
      if (sum_w >= 11'(MAX_POS)) begin
        pos_o    = 10'(MAX_POS);
        dir_o    = 1'b0;
        bounce_o = 1'b1;
      end else begin
        pos_o = sum_w[9:0];
      end
    end else begin
      if (pos_w <= lim_lo_w) begin
        pos_o    = 10'(MIN_POS);
        dir_o    = 1'b1;
        bounce_o = 1'b1;
      end else begin
        pos_o = 10'(pos_w - step_w);
      end
    end
  end

endmodule

// File: rtl/ball_motion.sv
// Frame-rate ball position update with bounce detection.
// Optional saturating bounce counter: define BALL_MOTION_BOUNCE_CNT_EN.
module ball_motion
  import ball_pkg::*;
#(
  parameter int unsigned BALL_SIZE = BALL_SIZE_DEF,
  parameter int unsigned H_ACTIVE  = H_ACTIVE_DEF,
  parameter int unsigned V_ACTIVE  = V_ACTIVE_DEF,
  parameter int unsigned INIT_X    = INIT_X_DEF,
  parameter int unsigned INIT_Y    = INIT_Y_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] hpos,
  input  logic [9:0] vpos,
  input  logic [1:0] speed,
  input  logic       pause,
  input  logic       load,
  input  logic [9:0] load_x,
  input  logic [9:0] load_y,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic       x_dir,
  output logic       y_dir,
  output logic       bounce_x,
  output logic       bounce_y,
  output logic       corner,
  output logic [7:0] bounce_count,
  output logic [1:0] dbg_state_o
);

  localparam int unsigned MIN_POS = BALL_SIZE;
  localparam int unsigned MAX_X   = H_ACTIVE - 1 - BALL_SIZE;
  localparam int unsigned MAX_Y   = V_ACTIVE - 1 - BALL_SIZE;

  ball_state_e state_q;
  logic        origin_q;
  logic [2:0]  step_q;
  logic [9:0]  ball_x_q, ball_y_q;
  logic        x_dir_q, y_dir_q;
  logic        bounce_x_q, bounce_y_q, corner_q;

  logic [9:0]  x_pos_d, y_pos_d;
  logic        x_dir_d, y_dir_d;
  logic        x_bounce_d, y_bounce_d;
  logic        origin_w, tick_w;

  // Tick fires on the rising edge of "beam at origin", so a held origin
  // produces exactly one tick.
  assign origin_w = (hpos == 10'd0) && (vpos == 10'd0);
  assign tick_w   = origin_w && !origin_q;

  ball_axis #(.MIN_POS(MIN_POS), .MAX_POS(MAX_X)) u_axis_x (
    .pos_i   (ball_x_q),
    .dir_i   (x_dir_q),
    .step_i  (step_q),
    .pos_o   (x_pos_d),
    .dir_o   (x_dir_d),
    .bounce_o(x_bounce_d)
  );

  ball_axis #(.MIN_POS(MIN_POS), .MAX_POS(MAX_Y)) u_axis_y (
    .pos_i   (ball_y_q),
    .dir_i   (y_dir_q),
    .step_i  (step_q),
    .pos_o   (y_pos_d),
    .dir_o   (y_dir_d),
    .bounce_o(y_bounce_d)
  );

  // The CALC->COMMIT edge registers the axis results, so positions and
  // pulses are visible exactly while the FSM sits in COMMIT.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      origin_q   <= 1'b0;
      step_q     <= 3'd1;
      ball_x_q   <= 10'(INIT_X);
      ball_y_q   <= 10'(INIT_Y);
      x_dir_q    <= 1'b1;
      y_dir_q    <= 1'b1;
      bounce_x_q <= 1'b0;
      bounce_y_q <= 1'b0;
      corner_q   <= 1'b0;
    end else begin
      origin_q   <= origin_w;
      bounce_x_q <= 1'b0;
      bounce_y_q <= 1'b0;
      corner_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (load) begin
            ball_x_q <= load_x;
            ball_y_q <= load_y;
          end else if (tick_w && !pause) begin
            step_q  <= {1'b0, speed} + 3'd1;
            state_q <= CALC;
          end
        end
        CALC: begin
          ball_x_q   <= x_pos_d;
          ball_y_q   <= y_pos_d;
          x_dir_q    <= x_dir_d;
          y_dir_q    <= y_dir_d;
          bounce_x_q <= x_bounce_d;
          bounce_y_q <= y_bounce_d;
          corner_q   <= x_bounce_d && y_bounce_d;
          state_q    <= COMMIT;
        end
        COMMIT:  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef BALL_MOTION_BOUNCE_CNT_EN
  logic [7:0] bounce_cnt_q;
  logic [8:0] cnt_sum_d;

  always_comb begin
    cnt_sum_d = {1'b0, bounce_cnt_q} + 9'(x_bounce_d) + 9'(y_bounce_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bounce_cnt_q <= 8'd0;
    end else if (state_q == CALC) begin
      bounce_cnt_q <= cnt_sum_d[8] ? 8'hFF : cnt_sum_d[7:0];
    end
  end

  assign bounce_count = bounce_cnt_q;
`else
  assign bounce_count = 8'd0;
`endif

  assign ball_x      = ball_x_q;
  assign ball_y      = ball_y_q;
  assign x_dir       = x_dir_q;
  assign y_dir       = y_dir_q;
  assign bounce_x    = bounce_x_q;
  assign bounce_y    = bounce_y_q;
  assign corner      = corner_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ball_motion.sv
// Self-checking bench for ball_motion: vector table, corner-case sequences
// and a COMMIT-cycle scoreboard.
module tb_ball_motion;
  import ball_pkg::*;

  localparam int W = 33;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] hpos, vpos;
  logic [1:0] speed;
  logic       pause;
  logic       load;
  logic [9:0] load_x, load_y;
  logic [9:0] ball_x, ball_y;
  logic       x_dir, y_dir;
  logic       bounce_x, bounce_y, corner;
  logic [7:0] bounce_count;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  ball_motion dut (
    .clk         (clk),
    .reset       (reset),
    .hpos        (hpos),
    .vpos        (vpos),
    .speed       (speed),
    .pause       (pause),
    .load        (load),
    .load_x      (load_x),
    .load_y      (load_y),
    .ball_x      (ball_x),
    .ball_y      (ball_y),
    .x_dir       (x_dir),
    .y_dir       (y_dir),
    .bounce_x    (bounce_x),
    .bounce_y    (bounce_y),
    .corner      (corner),
    .bounce_count(bounce_count),
    .dbg_state_o (dbg_state)
  );

  typedef struct {
    logic [9:0] lx, ly;
    logic [1:0] spd;
    logic [9:0] ex, ey;
    logic       exd, eyd, ebx, eby;
  } vec_t;

  vec_t            vecs[8];
  logic [W-1:0]    exp_q[$];
  int              checks = 0;
  int              errors = 0;
  int              exp_cnt = 0;
  bit              mon_en = 1'b0;
  bit              ddir;

  function automatic logic [W-1:0] pk(input logic [9:0] x, input logic [9:0] y,
                                      input logic xd, input logic yd,
                                      input logic bx, input logic by,
                                      input logic c, input logic [7:0] cnt);
    return {x, y, xd, yd, bx, by, c, cnt};
  endfunction

  function automatic logic [W-1:0] cur_pk();
    return pk(ball_x, ball_y, x_dir, y_dir, bounce_x, bounce_y, corner, bounce_count);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model the count alongside the expected frame result and queue it.
  task automatic expect_frame(input logic [9:0] ex, input logic [9:0] ey,
                              input logic exd, input logic eyd,
                              input logic ebx, input logic eby);
`ifdef BALL_MOTION_BOUNCE_CNT_EN
    exp_cnt = exp_cnt + int'(ebx) + int'(eby);
    if (exp_cnt > 255) exp_cnt = 255;
`endif
    exp_q.push_back(pk(ex, ey, exd, eyd, ebx, eby, ebx & eby, 8'(exp_cnt)));
  endtask

  task automatic do_load(input logic [9:0] lx, input logic [9:0] ly);
    load   = 1'b1;
    load_x = lx;
    load_y = ly;
    @(posedge clk); #1;
    load   = 1'b0;
  endtask

  // Origin held for one cycle; speed/pause scrambled afterwards must not matter.
  task automatic do_tick(input logic [1:0] spd, input logic p);
    speed = spd;
    pause = p;
    hpos  = 10'd0;
    vpos  = 10'd0;
    @(posedge clk); #1;
    hpos  = 10'($urandom_range(1, 639));
    vpos  = 10'($urandom_range(0, 479));
    speed = 2'($urandom_range(0, 3));
    pause = 1'($urandom_range(0, 1));
    repeat (2) begin
      @(posedge clk); #1;
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (dbg_state == COMMIT) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_commit: got %h with empty queue (t=%0t)", cur_pk(), $time);
        end else begin
          check("commit", 64'(cur_pk()), 64'(exp_q.pop_front()));
        end
      end else begin
        check("idle_pulses", 64'({bounce_x, bounce_y, corner}), 64'(0));
      end
    end
  end

  initial begin
    vecs[0] = '{lx:618, ly:100, spd:3, ex:619, ey:104, exd:0, eyd:1, ebx:1, eby:0};
    vecs[1] = '{lx:300, ly:458, spd:0, ex:299, ey:459, exd:0, eyd:0, ebx:0, eby:1};
    vecs[2] = '{lx:21,  ly:21,  spd:0, ex:20,  ey:20,  exd:1, eyd:1, ebx:1, eby:1};
    vecs[3] = '{lx:100, ly:200, spd:2, ex:103, ey:203, exd:1, eyd:1, ebx:0, eby:0};
    vecs[4] = '{lx:616, ly:456, spd:2, ex:619, ey:459, exd:0, eyd:0, ebx:1, eby:1};
    vecs[5] = '{lx:24,  ly:400, spd:3, ex:20,  ey:396, exd:1, eyd:0, ebx:1, eby:0};
    vecs[6] = '{lx:500, ly:22,  spd:1, ex:502, ey:20,  exd:1, eyd:1, ebx:0, eby:1};
    vecs[7] = '{lx:25,  ly:300, spd:3, ex:29,  ey:304, exd:1, eyd:1, ebx:0, eby:0};

    reset = 1'b1; hpos = 10'd1; vpos = 10'd1; speed = 2'd0; pause = 1'b0;
    load = 1'b0; load_x = 10'd0; load_y = 10'd0;
    repeat (3) @(posedge clk);
    #1;
    reset  = 1'b0;
    mon_en = 1'b1;
    check("reset_outputs", 64'(cur_pk()), 64'(pk(320, 240, 1, 1, 0, 0, 0, 0)));
    check("reset_state", 64'(dbg_state), 64'(IDLE));

    // Latency: unchanged one cycle after the tick, updated the cycle after.
    expect_frame(322, 242, 1, 1, 0, 0);
    speed = 2'd1; pause = 1'b0; hpos = 10'd0; vpos = 10'd0;
    @(posedge clk); #1;
    hpos = 10'd5;
    check("lat1_state", 64'(dbg_state), 64'(CALC));
    check("lat1_hold", 64'(cur_pk()), 64'(pk(320, 240, 1, 1, 0, 0, 0, 0)));
    @(posedge clk); #1;
    check("lat2_pos", 64'({ball_x, ball_y}), 64'({10'd322, 10'd242}));
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      do_load(vecs[i].lx, vecs[i].ly);
      expect_frame(vecs[i].ex, vecs[i].ey, vecs[i].exd, vecs[i].eyd, vecs[i].ebx, vecs[i].eby);
      do_tick(vecs[i].spd, 1'b0);
    end

    for (int k = 0; k < 3; k++) begin
      do_tick(2'd1, 1'b1);
      check("pause_hold", 64'(cur_pk()), 64'(pk(29, 304, 1, 1, 0, 0, 0, 8'(exp_cnt))));
    end
    expect_frame(31, 306, 1, 1, 0, 0);
    do_tick(2'd1, 1'b0);

    // Load coinciding with the tick wins and skips the frame.
    load = 1'b1; load_x = 10'd200; load_y = 10'd150; hpos = 10'd0; vpos = 10'd0;
    @(posedge clk); #1;
    load = 1'b0; hpos = 10'd7;
    check("load_tick_pos", 64'({ball_x, ball_y}), 64'({10'd200, 10'd150}));
    check("load_tick_state", 64'(dbg_state), 64'(IDLE));
    repeat (3) @(posedge clk);
    #1;
    check("load_tick_skip", 64'(cur_pk()), 64'(pk(200, 150, 1, 1, 0, 0, 0, 8'(exp_cnt))));

    // Load while in CALC is ignored.
    expect_frame(201, 151, 1, 1, 0, 0);
    speed = 2'd0; pause = 1'b0; hpos = 10'd0; vpos = 10'd0;
    @(posedge clk); #1;
    hpos = 10'd9; load = 1'b1; load_x = 10'd5; load_y = 10'd5;
    @(posedge clk); #1;
    load = 1'b0;
    @(posedge clk); #1;
    check("load_calc_ignored", 64'({ball_x, ball_y}), 64'({10'd201, 10'd151}));

    // Reset during CALC discards the in-flight update.
    speed = 2'd3; hpos = 10'd0; vpos = 10'd0;
    @(posedge clk); #1;
    hpos = 10'd11;
    check("rst_calc_pre", 64'(dbg_state), 64'(CALC));
    reset = 1'b1;
    @(posedge clk); #1;
    reset   = 1'b0;
    exp_cnt = 0;
    check("rst_calc_outputs", 64'(cur_pk()), 64'(pk(320, 240, 1, 1, 0, 0, 0, 0)));
    check("rst_calc_state", 64'(dbg_state), 64'(IDLE));
    @(posedge clk); #1;

    ddir = 1'b1;
    for (int n = 0; n < 130; n++) begin
      if (ddir) begin
        do_load(10'd619, 10'd459);
        expect_frame(619, 459, 0, 0, 1, 1);
      end else begin
        do_load(10'd20, 10'd20);
        expect_frame(20, 20, 1, 1, 1, 1);
      end
      do_tick(2'd0, 1'b0);
      ddir = !ddir;
    end
`ifdef BALL_MOTION_BOUNCE_CNT_EN
    check("sat_count", 64'(bounce_count), 64'(255));
`else
    check("sat_count", 64'(bounce_count), 64'(0));
`endif

    repeat (3) @(posedge clk);
    #1;
    check("queue_empty", 64'(exp_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ball_motion.md
BALL_MOTION -- requirements
Module: ball_motion

Interface
REQ-001 Parameter BALL_SIZE, default 20: ball radius in pixels; sets the bounce margin.
REQ-002 Parameter H_ACTIVE, default 640: visible width in pixels.
REQ-003 Parameter V_ACTIVE, default 480: visible height in pixels.
REQ-004 Parameter INIT_X, default 320: ball X loaded at reset.
REQ-005 Parameter INIT_Y, default 240: ball Y loaded at reset.
REQ-006 Port clk, input, 1 bit: the single clock (pixel clock); there is one clock and reset is synchronous and active-high.
REQ-007 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-008 Ports hpos and vpos, input, 10 bits each: beam position from the sync generator.
REQ-009 Port speed, input, 2 bits: step select; step = speed+1 pixels per frame.
REQ-010 Port pause, input, 1 bit: when high, frame updates are suppressed.
REQ-011 Ports load (1 bit), load_x (10 bits), load_y (10 bits), input: single-cycle position preload.
REQ-012 Ports ball_x and ball_y, output, 10 bits each: registered ball centre, consumed by the renderer.
REQ-013 Ports x_dir and y_dir, output, 1 bit each: 1 = right/down, 0 = left/up.
REQ-014 Ports bounce_x, bounce_y and corner, output, 1 bit each: one-cycle event pulses.
REQ-015 Port bounce_count, output, 8 bits: saturating bounce counter.

Function
REQ-016 Frame tick SHALL assert for one cycle when (hpos==0 && vpos==0) is high in the current cycle and was low in the previous cycle; the previous value is held in a register.
REQ-017 FSM SHALL have three states: IDLE, CALC and COMMIT; IDLE goes to CALC on a tick with pause low and load low; CALC goes to COMMIT unconditionally; COMMIT goes to IDLE unconditionally.
REQ-018 speed and pause SHALL be sampled only in the tick cycle; changes outside the tick cycle have no effect until the next tick.
REQ-019 In CALC, each axis SHALL compute its candidate position in 11-bit unsigned arithmetic so the value cannot wrap.
REQ-020 Bounds: MIN = BALL_SIZE; MAX_X = H_ACTIVE-1-BALL_SIZE; MAX_Y = V_ACTIVE-1-BALL_SIZE.
REQ-021 Moving positive: if pos+step >= MAX, the axis SHALL set pos = MAX, clear dir and raise the bounce flag; otherwise pos = pos+step.
REQ-022 Moving negative: if pos <= MIN+step, the axis SHALL set pos = MIN, set dir and raise the bounce flag; otherwise pos = pos-step.
REQ-023 In COMMIT, ball_x, ball_y, x_dir and y_dir SHALL update, and bounce_x/bounce_y SHALL pulse for exactly that cycle; outputs become visible 2 cycles after the tick.
REQ-024 corner SHALL pulse in COMMIT when bounce_x and bounce_y both pulse.
REQ-025 bounce_count SHALL add the number of bounce pulses in COMMIT (0, 1 or 2) and saturate at 255.
REQ-026 load SHALL act only in IDLE: next cycle ball_x = load_x and ball_y = load_y, with directions unchanged and no pulses.
REQ-027 If load and tick occur in the same cycle, load SHALL win and that frame's motion is skipped.
REQ-028 load while not in IDLE SHALL be ignored.
REQ-029 Outputs SHALL be stable between COMMIT cycles, so the renderer never sees a mid-frame change except at the frame origin.

Reset
REQ-030 On reset: state = IDLE, ball_x = INIT_X, ball_y = INIT_Y, x_dir = 1, y_dir = 1, all pulses = 0, bounce_count = 0, tick history = 0.
REQ-031 Reset in any state, including CALC or COMMIT, SHALL take priority and discard the in-flight update.

Configuration
REQ-032 Macro BALL_MOTION_BOUNCE_CNT_EN: when defined, bounce_count SHALL behave per REQ-025.
REQ-033 When BALL_MOTION_BOUNCE_CNT_EN is undefined, bounce_count SHALL be tied to 0 with no counter register; all other behaviour is unchanged.

Structure
REQ-034 Shared package ball_pkg SHALL hold the H_ACTIVE, V_ACTIVE, BALL_SIZE, INIT_X and INIT_Y defaults and the FSM state encoding.
REQ-035 Sub-module ball_axis (one-axis step/clamp/bounce per REQ-019..022) SHALL be instantiated twice, once for X and once for Y.

Verification
REQ-036 Reset, speed=1, one tick -> (322,242) exactly 2 cycles after the tick; no pulses.
REQ-037 load (618,100), x_dir=1, speed=3, tick -> ball_x=619, x_dir=0, bounce_x high for one cycle, bounce_count=1.
REQ-038 load (21,21), directions left/up, speed=0, tick -> (20,20), both directions become 1, corner high, bounce_count +2.
REQ-039 pause high across 3 ticks -> outputs unchanged; pause low before the 4th tick -> motion resumes at the default step.
REQ-040 Reset asserted during CALC -> next cycle (320,240), state IDLE, bounce_count=0, no pulses.
REQ-041 Force 130 corner bounces -> bounce_count holds at 255; with the macro undefined it stays 0 throughout.
